// File: rtl/mem_burst_pkg.sv
// Shared types for the word-to-byte memory burst engine: FSM states,
// sticky error bit positions and the endian-aware byte-lane mapping.
package mem_burst_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR_LOAD,
        WR_START,
        WR_XFER,
        RD_START,
        RD_XFER,
        DONE
    } state_t;

    localparam int ERR_RD_OVR = 0;
    localparam int ERR_WR_UDR = 1;

    // Lane (0 = least significant byte) that carries the idx-th byte on the PHY.
    function automatic int unsigned byte_lane(input int unsigned idx,
                                              input int unsigned nbytes,
                                              input bit          big_endian);
        return big_endian ? (nbytes - 1 - idx) : idx;
    endfunction

endpackage

// File: rtl/burst_byte_shifter.sv
// Word<->byte shifter: serialises a loaded word or assembles incoming bytes, in PHY byte order.
// Zero latency on byte_out/word_out (word_out includes a byte arriving this cycle); no backpressure.
module burst_byte_shifter
    import mem_burst_pkg::*;
#(
    parameter int WORD_BYTES = 4,
    parameter bit BIG_ENDIAN = 1'b1,
    localparam int IW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr,
    input  logic                    load,
    input  logic [8*WORD_BYTES-1:0] load_word,
    input  logic                    advance,
    output logic [7:0]              byte_out,
    input  logic                    byte_in_vld,
    input  logic [7:0]              byte_in,
    output logic [8*WORD_BYTES-1:0] word_out,
    output logic                    last_byte
);

    logic [WORD_BYTES-1:0][7:0] ser_q;
    logic [WORD_BYTES-1:0][7:0] asm_q;
    logic [WORD_BYTES-1:0][7:0] asm_merged;
    logic [IW-1:0]              idx;
    logic [IW-1:0]              lane;

    assign lane      = IW'(byte_lane(32'(idx), WORD_BYTES, BIG_ENDIAN));
    assign last_byte = (idx == IW'(WORD_BYTES - 1));
    assign byte_out  = ser_q[lane];
    assign word_out  = asm_merged;

    always_comb begin
        asm_merged = asm_q;
        if (byte_in_vld) begin
            asm_merged[lane] = byte_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ser_q <= '0;
            asm_q <= '0;
            idx   <= '0;
        end else begin
            if (load) begin
                ser_q <= load_word;
            end
            if (byte_in_vld) begin
                asm_q <= asm_merged;
            end
            if (clr || load) begin
                idx <= '0;
            end else if (advance || byte_in_vld) begin
                idx <= last_byte ? '0 : idx + IW'(1);
            end
        end
    end

endmodule

// File: rtl/memory_burst_engine.sv
// Burst engine between a word bus and a byte-serial PHY; phy_rd 1 cycle after accept, rdata 1 cycle after last byte.
// Bus backpressure via req/wdata/rdata valid-ready; a full read holding register drops new words and flags overrun.
module memory_burst_engine
    import mem_burst_pkg::*;
#(
    parameter int WORD_BYTES = 4,
    parameter int ADDR_W     = 22,
    parameter int BLEN_W     = 8,
    parameter bit BIG_ENDIAN = 1'b1,
    localparam int AB = $clog2(WORD_BYTES),
    localparam int DW = 8 * WORD_BYTES
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [ADDR_W-1:0]    req_addr,
    input  logic [BLEN_W-1:0]    req_len,
    input  logic                 wdata_valid,
    output logic                 wdata_ready,
    input  logic [DW-1:0]        wdata,
    output logic                 rdata_valid,
    input  logic                 rdata_ready,
    output logic [DW-1:0]        rdata,
    output logic                 rdata_last,
    output logic                 busy,
    output logic [1:0]           err,
    input  logic                 phy_ready,
    output logic                 phy_rd,
    output logic                 phy_we,
    output logic                 phy_end,
    output logic [ADDR_W+AB-1:0] phy_a,
    input  logic [7:0]           phy_dout,
    input  logic                 phy_byte_valid,
    output logic [7:0]           phy_din,
    input  logic                 phy_byte_req
);

    localparam int PA_W = ADDR_W + AB;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] addr_q;
    logic [BLEN_W-1:0] words_q;
    logic [DW-1:0]     hold_dat;
    logic              hold_vld, hold_last;
    logic [1:0]        err_q;

    logic              accept, final_word, hold_take;
    logic              wr_byte, wr_word_end, rd_byte, rd_word_end;
    logic              sh_load, sh_last;
    logic [DW-1:0]     sh_load_word, sh_word;
    logic [7:0]        sh_byte;

    assign accept      = req_valid && req_ready;
    assign final_word  = (words_q == BLEN_W'(1));
    assign hold_take   = hold_vld && rdata_ready;
    assign wr_byte     = (state == WR_XFER) && phy_byte_req;
    assign wr_word_end = wr_byte && sh_last;
    assign rd_byte     = (state == RD_XFER) && phy_byte_valid;
    assign rd_word_end = rd_byte && sh_last;

    // A missing write word at a boundary is replaced by zeros so the PHY stream keeps going.
    assign sh_load      = ((state == WR_LOAD) && wdata_valid) || (wr_word_end && !final_word);
    assign sh_load_word = wdata_valid ? wdata : '0;

    burst_byte_shifter #(
        .WORD_BYTES (WORD_BYTES),
        .BIG_ENDIAN (BIG_ENDIAN)
    ) u_shifter (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr         (accept),
        .load        (sh_load),
        .load_word   (sh_load_word),
        .advance     (wr_byte),
        .byte_out    (sh_byte),
        .byte_in_vld (rd_byte),
        .byte_in     (phy_dout),
        .word_out    (sh_word),
        .last_byte   (sh_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        req_ready   = 1'b0;
        wdata_ready = 1'b0;
        phy_rd      = 1'b0;
        phy_we      = 1'b0;
        phy_end     = 1'b0;
        case (state)
            IDLE: begin
                req_ready = phy_ready;
                if (req_valid && phy_ready) begin
                    state_nxt = req_we ? WR_LOAD : RD_START;
                end
            end
            WR_LOAD: begin
                wdata_ready = 1'b1;
                if (wdata_valid) begin
                    state_nxt = WR_START;
                end
            end
            WR_START: begin
                phy_we    = 1'b1;
                state_nxt = WR_XFER;
            end
            WR_XFER: begin
                if (wr_word_end) begin
                    if (final_word) begin
                        phy_end   = 1'b1;
                        state_nxt = DONE;
                    end else begin
                        wdata_ready = 1'b1;
                    end
                end
            end
            RD_START: begin
                phy_rd    = 1'b1;
                state_nxt = RD_XFER;
            end
            RD_XFER: begin
                if (rd_word_end && final_word) begin
                    phy_end   = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (phy_ready && !hold_vld) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q    <= '0;
            words_q   <= '0;
            hold_dat  <= '0;
            hold_vld  <= 1'b0;
            hold_last <= 1'b0;
            err_q     <= '0;
        end else begin
            if (accept) begin
                addr_q  <= req_addr;
                words_q <= (req_len == '0) ? BLEN_W'(1) : req_len;
                err_q   <= '0;
            end
            if (wr_word_end || rd_word_end) begin
                words_q <= words_q - BLEN_W'(1);
            end
            if (wr_word_end && !final_word && !wdata_valid) begin
                err_q[ERR_WR_UDR] <= 1'b1;
            end
            // A word landing while the old one is taken this cycle is not an overrun.
            if (rd_word_end && hold_vld && !hold_take) begin
                err_q[ERR_RD_OVR] <= 1'b1;
            end else if (rd_word_end) begin
                hold_dat  <= sh_word;
                hold_last <= final_word;
                hold_vld  <= 1'b1;
            end else if (hold_take) begin
                hold_vld <= 1'b0;
            end
        end
    end

    assign rdata_valid = hold_vld;
    assign rdata       = hold_dat;
    assign rdata_last  = hold_last;
    assign busy        = (state != IDLE);
    assign err         = err_q;
    assign phy_din     = sh_byte;
    assign phy_a       = PA_W'(addr_q) << AB;

endmodule

// File: tb/tb_memory_burst_engine.sv
// Self-checking bench: a big-endian and a little-endian engine share one stimulus stream;
// a scripted PHY drives bytes and scoreboards read words and written bytes.
module tb_memory_burst_engine;

    logic        clk;
    logic        rst_n;
    logic        req_valid, req_we;
    logic [21:0] req_addr;
    logic [7:0]  req_len;
    logic        wdata_valid;
    logic [31:0] wdata;
    logic        rdata_ready;
    logic        phy_ready, phy_byte_valid, phy_byte_req;
    logic [7:0]  phy_dout;

    logic        req_ready, wdata_ready, rdata_valid, rdata_last, busy;
    logic [31:0] rdata;
    logic [1:0]  err;
    logic        phy_rd, phy_we, phy_end;
    logic [23:0] phy_a;
    logic [7:0]  phy_din;

    logic        req_ready_le, wdata_ready_le, rdata_valid_le, rdata_last_le, busy_le;
    logic [31:0] rdata_le;
    logic [1:0]  err_le;
    logic        phy_rd_le, phy_we_le, phy_end_le;
    logic [23:0] phy_a_le;
    logic [7:0]  phy_din_le;

    int checks = 0;
    int errors = 0;
    int we_cnt = 0;
    int end_cnt = 0;
    int end_bv_cnt = 0;

    // {rdata_last, big-endian word, little-endian word}
    logic [64:0] exp_rd[$];
    logic [64:0] obs_rd[$];
    logic [7:0]  exp_din[$];
    logic [7:0]  obs_din[$];

    memory_burst_engine #(.WORD_BYTES(4), .ADDR_W(22), .BLEN_W(8), .BIG_ENDIAN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_len(req_len),
        .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
        .rdata_valid(rdata_valid), .rdata_ready(rdata_ready), .rdata(rdata),
        .rdata_last(rdata_last), .busy(busy), .err(err),
        .phy_ready(phy_ready), .phy_rd(phy_rd), .phy_we(phy_we), .phy_end(phy_end),
        .phy_a(phy_a), .phy_dout(phy_dout), .phy_byte_valid(phy_byte_valid),
        .phy_din(phy_din), .phy_byte_req(phy_byte_req)
    );

    memory_burst_engine #(.WORD_BYTES(4), .ADDR_W(22), .BLEN_W(8), .BIG_ENDIAN(1'b0)) dut_le (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready_le), .req_we(req_we),
        .req_addr(req_addr), .req_len(req_len),
        .wdata_valid(wdata_valid), .wdata_ready(wdata_ready_le), .wdata(wdata),
        .rdata_valid(rdata_valid_le), .rdata_ready(rdata_ready), .rdata(rdata_le),
        .rdata_last(rdata_last_le), .busy(busy_le), .err(err_le),
        .phy_ready(phy_ready), .phy_rd(phy_rd_le), .phy_we(phy_we_le), .phy_end(phy_end_le),
        .phy_a(phy_a_le), .phy_dout(phy_dout), .phy_byte_valid(phy_byte_valid),
        .phy_din(phy_din_le), .phy_byte_req(phy_byte_req)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock: observe on the falling edge, return just after the rising edge.
    task automatic step();
        @(negedge clk);
        if (phy_we) we_cnt++;
        if (phy_end) begin
            end_cnt++;
            if (phy_byte_valid) end_bv_cnt++;
        end
        if (rdata_valid && rdata_ready) obs_rd.push_back({rdata_last, rdata, rdata_le});
        if (phy_byte_req) obs_din.push_back(phy_din);
        @(posedge clk);
        #1;
    endtask

    task automatic issue_req(input logic we, input logic [21:0] addr, input logic [7:0] len);
        int n = 0;
        req_we = we; req_addr = addr; req_len = len; req_valid = 1'b1;
        while (!req_ready && n < 50) begin step(); n++; end
        checks++;
        if (!req_ready) begin errors++; $display("FAIL req_accept timeout: req_ready=%b required 1", req_ready); end
        step();
        req_valid = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        step(); step();
        phy_byte_valid = 1'b1; phy_dout = b;
        step();
        phy_byte_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 200) begin step(); n++; end
        checks++;
        if (busy) begin errors++; $display("FAIL %s idle_timeout: busy=%b required 0", tag, busy); end
    endtask

    task automatic run_write(input logic [7:0] len, input logic [31:0] w0, input logic [31:0] w1,
                             input logic [31:0] w2, input int nw, input int miss);
        logic [31:0] w [3];
        int n = 0;
        w[0] = w0; w[1] = w1; w[2] = w2;
        issue_req(1'b1, 22'h100, len);
        wdata = w[0]; wdata_valid = 1'b1;
        for (int i = 3; i >= 0; i--) exp_din.push_back(w[0][i*8 +: 8]);
        while (!wdata_ready && n < 50) begin step(); n++; end
        step();
        checks++;
        if (phy_we !== 1'b1) begin errors++; $display("FAIL wr_start_latency: phy_we=%b required 1", phy_we); end
        for (int k = 0; k < nw; k++) begin
            if (k + 1 < nw && k + 1 == miss) begin
                wdata_valid = 1'b0;
                repeat (4) exp_din.push_back(8'h00);
            end else if (k + 1 < nw) begin
                wdata = w[k+1]; wdata_valid = 1'b1;
                for (int i = 3; i >= 0; i--) exp_din.push_back(w[k+1][i*8 +: 8]);
            end else begin
                wdata_valid = 1'b0;
            end
            for (int i = 0; i < 4; i++) begin
                step(); step();
                phy_byte_req = 1'b1;
                step();
                phy_byte_req = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if (req_ready !== 1'b1 || req_ready_le !== 1'b1) begin
            errors++; $display("FAIL reset req_ready: got %b/%b required 1/1", req_ready, req_ready_le);
        end
        checks++;
        if ({busy, rdata_valid, rdata_last, wdata_ready, phy_rd, phy_we, phy_end} !== 7'b0) begin
            errors++; $display("FAIL reset controls: got %b required 0000000",
                               {busy, rdata_valid, rdata_last, wdata_ready, phy_rd, phy_we, phy_end});
        end
        checks++;
        if (rdata !== 32'h0 || err !== 2'b00 || phy_a !== 24'h0 || phy_din !== 8'h0) begin
            errors++; $display("FAIL reset data: rdata=%h err=%b phy_a=%h phy_din=%h required zeros",
                               rdata, err, phy_a, phy_din);
        end
        checks++;
        if ({busy_le, rdata_valid_le, rdata_last_le, wdata_ready_le, phy_rd_le, phy_we_le, phy_end_le,
             rdata_le, err_le, phy_a_le, phy_din_le} !== '0) begin
            errors++; $display("FAIL reset le_outputs: rdata=%h err=%b phy_a=%h required zeros",
                               rdata_le, err_le, phy_a_le);
        end
        phy_ready = 1'b0;
        #1;
        checks++;
        if (req_ready !== 1'b0) begin errors++; $display("FAIL reset req_ready_follow: got %b required 0", req_ready); end
        phy_ready = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single_read();
        logic [64:0] e, o;
        int e0, bv0;
        issue_req(1'b0, 22'h000010, 8'd1);
        checks++;
        if (phy_rd !== 1'b1) begin errors++; $display("FAIL single_read phy_rd_latency: got %b required 1", phy_rd); end
        checks++;
        if (phy_a !== 24'h000040) begin errors++; $display("FAIL single_read phy_a: got %h required 000040", phy_a); end
        exp_rd.push_back({1'b1, 32'h12345678, 32'h78563412});
        e0 = end_cnt; bv0 = end_bv_cnt;
        send_byte(8'h12); send_byte(8'h34); send_byte(8'h56);
        checks++;
        if (end_cnt != e0) begin errors++; $display("FAIL single_read early_end: got %0d pulses required 0", end_cnt - e0); end
        send_byte(8'h78);
        checks++;
        if (end_bv_cnt - bv0 != 1) begin errors++; $display("FAIL single_read end_on_4th: got %0d required 1", end_bv_cnt - bv0); end
        checks++;
        if (rdata_valid !== 1'b1) begin errors++; $display("FAIL single_read rdata_latency: got %b required 1", rdata_valid); end
        step();
        wait_idle("single_read");
        while (exp_rd.size() > 0) begin
            e = exp_rd.pop_front();
            o = (obs_rd.size() > 0) ? obs_rd.pop_front() : 'x;
            checks++;
            if (o !== e) begin errors++; $display("FAIL single_read word: got %h required %h", o, e); end
        end
    endtask

    task automatic test_write_burst();
        logic [7:0] e, o;
        int we0 = we_cnt;
        int e0 = end_cnt;
        run_write(8'd3, 32'hA1B2C3D4, 32'h01020304, 32'hDEADBEEF, 3, -1);
        wait_idle("write_burst");
        while (exp_din.size() > 0) begin
            e = exp_din.pop_front();
            o = (obs_din.size() > 0) ? obs_din.pop_front() : 'x;
            checks++;
            if (o !== e) begin errors++; $display("FAIL write_burst phy_din: got %h required %h", o, e); end
        end
        checks++;
        if (obs_din.size() != 0) begin errors++; $display("FAIL write_burst extra_bytes: got %0d required 0", obs_din.size()); end
        checks++;
        if (we_cnt - we0 != 1 || end_cnt - e0 != 1) begin
            errors++; $display("FAIL write_burst pulses: we=%0d end=%0d required 1/1", we_cnt - we0, end_cnt - e0);
        end
        checks++;
        if (err !== 2'b00) begin errors++; $display("FAIL write_burst err: got %b required 00", err); end
    endtask

    task automatic test_overrun();
        logic [64:0] e, o;
        int e0;
        rdata_ready = 1'b0;
        issue_req(1'b0, 22'h000020, 8'd2);
        exp_rd.push_back({1'b0, 32'hCAFEF00D, 32'h0DF0FECA});
        send_byte(8'hCA); send_byte(8'hFE); send_byte(8'hF0); send_byte(8'h0D);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        checks++;
        if (err !== 2'b01) begin errors++; $display("FAIL overrun err: got %b required 01", err); end
        checks++;
        if (rdata !== 32'hCAFEF00D || rdata_last !== 1'b0 || rdata_valid !== 1'b1) begin
            errors++; $display("FAIL overrun held: rdata=%h last=%b vld=%b required cafef00d/0/1",
                               rdata, rdata_last, rdata_valid);
        end
        step(); step(); step();
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL overrun wait_drain: busy=%b required 1", busy); end
        rdata_ready = 1'b1;
        step();
        wait_idle("overrun");
        checks++;
        if (err !== 2'b01) begin errors++; $display("FAIL overrun sticky: got %b required 01", err); end
        issue_req(1'b0, 22'h000005, 8'd0);
        checks++;
        if (err !== 2'b00) begin errors++; $display("FAIL overrun clear_on_accept: got %b required 00", err); end
        checks++;
        if (phy_a !== 24'h000014) begin errors++; $display("FAIL len0 phy_a: got %h required 000014", phy_a); end
        exp_rd.push_back({1'b1, 32'h9ABCDEF0, 32'hF0DEBC9A});
        e0 = end_cnt;
        send_byte(8'h9A); send_byte(8'hBC); send_byte(8'hDE); send_byte(8'hF0);
        step();
        wait_idle("len0_read");
        checks++;
        if (end_cnt - e0 != 1) begin errors++; $display("FAIL len0 phy_end: got %0d required 1", end_cnt - e0); end
        while (exp_rd.size() > 0) begin
            e = exp_rd.pop_front();
            o = (obs_rd.size() > 0) ? obs_rd.pop_front() : 'x;
            checks++;
            if (o !== e) begin errors++; $display("FAIL overrun word: got %h required %h", o, e); end
        end
        checks++;
        if (obs_rd.size() != 0) begin errors++; $display("FAIL overrun extra_words: got %0d required 0", obs_rd.size()); end
    endtask

    task automatic test_write_underrun();
        logic [7:0] e, o;
        run_write(8'd2, 32'h11223344, 32'h55667788, 32'h0, 2, 1);
        wait_idle("write_underrun");
        while (exp_din.size() > 0) begin
            e = exp_din.pop_front();
            o = (obs_din.size() > 0) ? obs_din.pop_front() : 'x;
            checks++;
            if (o !== e) begin errors++; $display("FAIL write_underrun phy_din: got %h required %h", o, e); end
        end
        checks++;
        if (err !== 2'b10) begin errors++; $display("FAIL write_underrun err: got %b required 10", err); end
    endtask

    task automatic test_reset_mid_read();
        logic [64:0] e, o;
        int e0;
        issue_req(1'b0, 22'h000003, 8'd1);
        send_byte(8'h12); send_byte(8'h34);
        e0 = end_cnt;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, rdata_valid, rdata_last, wdata_ready, phy_rd, phy_we, phy_end} !== 7'b0) begin
            errors++; $display("FAIL mid_reset controls: got %b required 0000000",
                               {busy, rdata_valid, rdata_last, wdata_ready, phy_rd, phy_we, phy_end});
        end
        checks++;
        if (rdata !== 32'h0 || err !== 2'b00 || phy_a !== 24'h0 || phy_din !== 8'h0) begin
            errors++; $display("FAIL mid_reset data: rdata=%h err=%b phy_a=%h phy_din=%h required zeros",
                               rdata, err, phy_a, phy_din);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
        checks++;
        if (req_ready !== 1'b1 || end_cnt != e0) begin
            errors++; $display("FAIL mid_reset after: req_ready=%b end_pulses=%0d required 1/0", req_ready, end_cnt - e0);
        end
        issue_req(1'b0, 22'h000007, 8'd0);
        exp_rd.push_back({1'b1, 32'h0BADF00D, 32'h0DF0AD0B});
        send_byte(8'h0B); send_byte(8'hAD); send_byte(8'hF0); send_byte(8'h0D);
        step();
        wait_idle("post_reset_read");
        checks++;
        if (end_cnt - e0 != 1) begin errors++; $display("FAIL post_reset phy_end: got %0d required 1", end_cnt - e0); end
        while (exp_rd.size() > 0) begin
            e = exp_rd.pop_front();
            o = (obs_rd.size() > 0) ? obs_rd.pop_front() : 'x;
            checks++;
            if (o !== e) begin errors++; $display("FAIL post_reset word: got %h required %h", o, e); end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_len = '0;
        wdata_valid = 1'b0; wdata = '0; rdata_ready = 1'b1;
        phy_ready = 1'b1; phy_dout = '0; phy_byte_valid = 1'b0; phy_byte_req = 1'b0;

        test_reset();
        test_single_read();
        test_write_burst();
        test_overrun();
        test_write_underrun();
        test_reset_mid_read();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/memory_burst_engine.md
# memory_burst_engine

Parametrised word-to-byte burst engine between the CPU/cache bus and a byte-serial memory PHY (PSRAM quad-SPI controller class). Accepts a burst request of N words, then streams write words out, or read words in, as bytes with valid/ready handshakes on the bus side. It is the single-clock, read-and-write-burst successor of the current PSRAM front-end. It adds configurable word width, byte order, bus-side back-pressure and sticky overrun/underrun reporting.

## Interface
- WORD_BYTES, 4, bytes per bus word (≥1, power of two); AB = log2(WORD_BYTES)
- ADDR_W, 22, word-address width
- BLEN_W, 8, burst-length counter width
- BIG_ENDIAN, 1, 1: word MSB byte first on the PHY; 0: LSB byte first
- clk  in  1  single clock for the bus side and the PHY side
- rst_n  in  1  asynchronous, active-low reset
- req_valid / req_ready  in / out  1  request handshake
- req_we  in  1  1 write burst, 0 read burst
- req_addr  in  ADDR_W  start word address
- req_len  in  BLEN_W  words in the burst; 0 is treated as 1
- wdata_valid / wdata_ready  in / out  1  write-word handshake
- wdata  in  8*WORD_BYTES  write word
- rdata_valid / rdata_ready  out / in  1  read-word handshake
- rdata  out  8*WORD_BYTES  read word
- rdata_last  out  1  qualifies the final word of the burst
- busy  out  1  high in every state other than IDLE
- err  out  2  sticky flags: [0] read overrun, [1] write underrun; cleared on req accept
- phy_ready  in  1  PHY idle and initialised
- phy_rd, phy_we  out  1  one-cycle start pulses
- phy_end  out  1  one-cycle end-of-transfer pulse (covers both rend and wend)
- phy_a  out  ADDR_W+AB  byte address = {req_addr, AB'b0}
- phy_dout  in  8  read byte, qualified by phy_byte_valid (one-cycle pulse)
- phy_din  out  8  write byte; phy_byte_req pulse means the PHY consumed the current byte
- The PHY guarantees ≥2 cycles between byte pulses.

## Operation
- States: IDLE, WR_LOAD, WR_START, WR_XFER, RD_START, RD_XFER, DONE.
- IDLE:
  - req_ready = phy_ready.
  - On accept: latch addr/we/len (len 0 → 1), clear err, load the word counter.
  - Go to WR_LOAD if we, else RD_START.
- WR_LOAD:
  - wdata_ready = 1.
  - On wdata accept: load the shifter, byte index = 0, go to WR_START.
- WR_START: pulse phy_we for one cycle, go to WR_XFER.
- WR_XFER:
  - phy_din = current byte, in BIG_ENDIAN order.
  - On phy_byte_req: advance the byte index.
  - On the last byte of a word that is not the final word: sample wdata in the same cycle with wdata_ready = 1.
    - If wdata_valid = 0: set err[1], load zeros, continue.
  - On the last byte of the final word: pulse phy_end, go to DONE.
- RD_START: pulse phy_rd for one cycle, go to RD_XFER.
- RD_XFER:
  - On phy_byte_valid: store phy_dout at the byte-index lane.
  - On the last byte of a word: move the assembled word to the output holding register; rdata_last = (words remaining == 1).
    - If the holding register is still full and not being taken this cycle: set err[0], drop the new word, keep the old one.
  - phy_end pulses in the same cycle as the final byte_valid; go to DONE.
- DONE:
  - Wait for phy_ready = 1 and an empty holding register, then go to IDLE.
  - phy_end is never repeated.
- Counters wrap nowhere: the word counter counts len→0, and the byte index runs 0..WORD_BYTES-1.
- phy_a is held constant from accept until IDLE; the PHY auto-increments internally.

## Timing
- Reset (rst_n low, asynchronous):
  - state IDLE.
  - All outputs 0 except req_ready, which follows phy_ready.
  - rdata 0, err 0.
- Reset mid-burst aborts immediately. No phy_end is issued; the PHY is reset on the same rst_n.
- Latency:
  - Request accept → phy_rd: 1 cycle.
  - Request accept → phy_we: 1 cycle after the first wdata accept.
  - Last read byte_valid → rdata_valid: 1 cycle.
- rdata/rdata_last are stable while rdata_valid && !rdata_ready. The holding register frees on the handshake cycle.
- Simultaneous last-byte arrival and rdata handshake: not an overrun; the new word is loaded.
- phy_din is updated the cycle after phy_byte_req, satisfying the 2-cycle PHY spacing.

## Structure
- Package mem_burst_pkg:
  - state enum.
  - err bit indices (ERR_RD_OVR = 0, ERR_WR_UDR = 1).
  - helper function for byte-lane selection by endianness.
- Sub-module burst_byte_shifter (parametrised by WORD_BYTES, BIG_ENDIAN):
  - serialise port: load word, byte_out, advance.
  - assemble port: byte_in, store at lane, word_out, index, last_byte flag.
- The top level holds the FSM, counters, holding register and handshakes. Target is about 250 lines total.

## Test plan
- Single read, WORD_BYTES=4, BIG_ENDIAN=1:
  - Stimulus: addr 0x000010, PHY bytes 0x12,0x34,0x56,0x78.
  - Required: phy_a = 0x000040; rdata = 0x12345678 with rdata_last = 1; phy_end on the 4th byte_valid.
- 3-word write burst:
  - Stimulus: wdata 0xA1B2C3D4, 0x01020304, 0xDEADBEEF.
  - Required: phy_din sequence A1 B2 C3 D4 01 02 03 04 DE AD BE EF; exactly one phy_we and one phy_end; err = 0.
- BIG_ENDIAN=0 read, bytes 0x12,0x34,0x56,0x78 → rdata = 0x78563412.
- Read burst len 2, rdata_ready held low:
  - Required: the first word is held; err[0] = 1 at the second word; rdata still = the first word; the next req accept clears err.
- Write burst len 2 with wdata_valid low at the word boundary → bytes 5–8 = 0x00, err[1] = 1.
- rst_n low mid-read after 2 bytes:
  - Required: asynchronous return to IDLE with all outputs 0.
  - After release with phy_ready = 1: req_ready = 1 and a new read completes correctly; also check req_len = 0 yields a single word.
